bnn_weight_streamer: RTL and testbench
======================================

// Module: bnn_weight_streamer
// PURPOSE
//  Transmit side of the BNN nibble weight-load interface. Accepts whole 8-bit neuron weights over a
//  valid/ready byte stream, buffers them in a small FIFO, and drives load_en + 4-bit nibble
//  (low nibble, then high nibble, on back-to-back cycles) into the BNN's weight-load port.
//  Sequences exactly NUM_NEURONS weights per session; sits between host/SPI front-end and the BNN core.
// PARAMETERS
//  NUM_NEURONS  16  weights sent per session (one byte per neuron)
//  FIFO_DEPTH   4   byte FIFO entries, power of 2, >=2
//  IDX_W        5   width of neuron_idx; must hold NUM_NEURONS
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      1-cycle pulse: open session (ignored unless IDLE)
//  abort        in   1      1-cycle pulse: end session early
//  w_data       in   8      weight byte, bit i = weight for input i
//  w_valid      in   1      w_data valid
//  w_ready      out  1      byte accepted when w_valid & w_ready at clk edge
//  load_en      out  1      registered; drives BNN load enable
//  load_nibble  out  4      registered; drives BNN weight nibble
//  neuron_idx   out  IDX_W  neurons fully sent this session
//  busy         out  1      high in LO/HI states
//  done         out  1      1-cycle pulse when session completes (normal or abort)
//  checksum     out  8      XOR of sent bytes (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, load_en=0, load_nibble=0, neuron_idx=0, busy=0, done=0,
//   w_ready=0, checksum=0. Reset mid-session discards FIFO and any half-sent byte.
//  FSM: IDLE -start-> LO (neuron_idx<=0, accept count<=0).
//   LO: FIFO non-empty -> load_en<=1, load_nibble<=head[3:0], go HI; empty -> load_en<=0, stay.
//   HI: load_en<=1, load_nibble<=head[7:4], pop head, neuron_idx+1; if neuron_idx+1==NUM_NEURONS
//       or abort pending -> DONE, else LO.
//   DONE: load_en<=0, load_nibble<=0, done=1 for exactly this cycle, next IDLE.
//  Pairing: the two nibbles of a byte are ALWAYS on consecutive cycles with load_en=1; gaps only
//   between bytes (load_en=0). A byte is never split across a stall.
//  w_ready = busy & FIFO not full & accepted_count < NUM_NEURONS; bytes beyond NUM_NEURONS refused.
//  Simultaneous push and pop in HI with full FIFO: pop frees a slot only from the next cycle
//   (w_ready uses current-cycle full flag).
//  Latency: byte written into empty FIFO at edge t -> low nibble on load_en at edge t+1, high at t+2.
//   Back-to-back bytes stream at 2 cycles/byte, load_en continuously high.
//  abort: in IDLE/DONE ignored; in LO -> DONE next edge; in HI -> latched, current high nibble
//   still sent, then DONE. abort+start same cycle: abort wins. On DONE after abort, FIFO flushed.
//  start while busy ignored. neuron_idx holds final count until next start.
// CONFIGURATION
//  WSTREAM_CHECKSUM_EN defined: checksum = XOR of every byte whose high nibble was sent this
//   session; cleared to 0 on start; updated in HI; holds after done.
//  Not defined: checksum tied to 8'h00, no checksum register synthesised.
// TESTING
//  1 reset, start, push 16 bytes 0x00..0x0F back-to-back -> 32 cycles load_en=1, nibbles
//    0,0,1,0,2,0..F,0; done pulse once; neuron_idx=16; checksum=0x00 (if _EN).
//  2 start, push 0xA5, 3-cycle gap, push 0x3C -> load_en 1,1,0,0,0,1,1; nibbles 5,A,..,C,3.
//  3 start, hold w_valid=1 with 20 bytes -> w_ready drops after 16 accepted; 32 load_en cycles.
//  4 start, push 0xF0, abort on high-nibble cycle -> 0xF still sent, done next, neuron_idx=1.
//  5 fill FIFO with FIFO_DEPTH bytes while stalled-free -> w_ready=0 when full; no byte lost.
//  6 assert reset during HI -> load_en=0, busy=0, FIFO empty immediately (async); start works after.

Source files
------------

// File: rtl/bnn_weight_streamer.sv
// bnn_weight_streamer: streams buffered 8-bit neuron weights into the BNN load port as low/high nibble pairs
//  clk, reset                 rising-edge clock, asynchronous active-high reset
//  start, abort               session open / early-close pulses
//  w_data, w_valid, w_ready   byte input stream (valid/ready)
//  load_en, load_nibble       registered BNN weight-load outputs
//  neuron_idx                 neurons fully sent this session
//  busy, done                 session active / one-cycle completion pulse
//  checksum                   XOR of sent bytes when WSTREAM_CHECKSUM_EN is defined, else 8'h00
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int IDX_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       w_data,
  input  logic             w_valid,
  output logic             w_ready,
  output logic             load_en,
  output logic [3:0]       load_nibble,
  output logic [IDX_W-1:0] neuron_idx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       checksum
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS);
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [IDX_W-1:0] acc_cnt;
  logic full, empty, push;
  logic [7:0] head;
  // pointers carry one extra wrap bit so full and empty are distinguishable
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign head = mem[rd_ptr[AW-1:0]];
  assign busy = state == LO || state == HI;
  assign done = state == DONE;
  assign w_ready = busy && !full && acc_cnt < LAST;
  assign push = w_valid && w_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= w_data;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      acc_cnt     <= '0;
      neuron_idx  <= '0;
      load_en     <= 1'b0;
      load_nibble <= 4'h0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        acc_cnt <= acc_cnt + 1'b1;
      end
      case (state)
        IDLE: if (start && !abort) begin
          state      <= LO;
          neuron_idx <= '0;
          acc_cnt    <= '0;
        end
        // a byte is only started when it is already buffered, so its high nibble always follows next cycle
        LO: if (abort) begin
          state   <= DONE;
          load_en <= 1'b0;
        end else if (!empty) begin
          state       <= HI;
          load_en     <= 1'b1;
          load_nibble <= head[3:0];
        end else load_en <= 1'b0;
        // an abort seen here still lets the high nibble go out before closing
        HI: begin
          load_en     <= 1'b1;
          load_nibble <= head[7:4];
          rd_ptr      <= rd_ptr + 1'b1;
          neuron_idx  <= neuron_idx + 1'b1;
          state       <= (neuron_idx + 1'b1 == LAST || abort) ? DONE : LO;
        end
        // leftover bytes from an aborted session are dropped here
        DONE: begin
          state       <= IDLE;
          load_en     <= 1'b0;
          load_nibble <= 4'h0;
          wr_ptr      <= '0;
          rd_ptr      <= '0;
        end
      endcase
    end
  end
`ifdef WSTREAM_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) checksum <= 8'h00;
    else if (state == IDLE && start && !abort) checksum <= 8'h00;
    else if (state == HI) checksum <= checksum ^ head;
`else
  assign checksum = 8'h00;
`endif
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// tb_bnn_weight_streamer: directed and randomized checks of bnn_weight_streamer against a byte-queue model
module tb_bnn_weight_streamer;
  localparam int NN = 16;
  logic clk = 0, reset = 1, start = 0, abort = 0, w_valid = 0;
  logic [7:0] w_data = 0;
  logic w_ready, load_en, busy, done;
  logic [3:0] load_nibble;
  logic [4:0] neuron_idx;
  logic [7:0] checksum;
  int vectors = 0, miscompares = 0;
  logic [3:0] obs[$];
  int done_cnt = 0, pair_err = 0, rises = 0, run = 0, accepted = 0;
  bit saw_full = 0;
  logic prev_en = 0;

  bnn_weight_streamer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .w_data(w_data),
    .w_valid(w_valid), .w_ready(w_ready), .load_en(load_en), .load_nibble(load_nibble),
    .neuron_idx(neuron_idx), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_en) begin
      obs.push_back(load_nibble);
      run++;
      if (!prev_en) rises++;
    end else begin
      if (run % 2 != 0) pair_err++;
      run = 0;
    end
    prev_en = load_en;
    if (done) done_cnt++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int bound, output bit acc);
    w_data = b;
    w_valid = 1;
    acc = 0;
    for (int i = 0; i < bound && !acc; i++) begin
      if (w_ready) acc = 1;
      else if (busy && accepted < NN) saw_full = 1;
      step();
    end
    w_valid = 0;
  endtask

  task automatic session(input logic [7:0] q[$], input int gap);
    logic [7:0] x;
    int bad;
    bit acc;
    x = 0;
    bad = 0;
    pulse_start();
    obs.delete();
    done_cnt = 0; pair_err = 0; rises = 0; saw_full = 0; accepted = 0;
    foreach (q[i]) begin
      repeat ($urandom_range(gap, 0)) step();
      push_byte(q[i], i < NN ? 60 : 3, acc);
      if (i < NN) begin
        chk("accept", acc, 1);
        x ^= q[i];
        accepted++;
      end else chk("refuse", acc, 0);
    end
    for (int i = 0; i < 100 && done_cnt == 0; i++) step();
    step();
    step();
    chk("done_pulses", done_cnt, 1);
    chk("idx_final", neuron_idx, accepted);
    chk("busy_end", busy, 0);
    chk("stream_len", obs.size(), 2 * accepted);
    for (int i = 0; i < accepted; i++)
      if (2 * i + 1 >= obs.size() || obs[2*i] !== q[i][3:0] || obs[2*i+1] !== q[i][7:4]) bad++;
    chk("stream_data", bad, 0);
    chk("pairing", pair_err, 0);
`ifdef WSTREAM_CHECKSUM_EN
    chk("checksum", checksum, x);
`else
    chk("checksum_tied", checksum, 0);
`endif
  endtask

  initial begin
    logic [7:0] q[$];
    bit en_e[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [3:0] nb_e[7] = '{4'h5, 4'hA, 4'h0, 4'h0, 4'h0, 4'hC, 4'h3};
    step();
    step();
    chk("rst_load_en", load_en, 0);
    chk("rst_nibble", load_nibble, 0);
    chk("rst_idx", neuron_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_checksum", checksum, 0);
    reset = 0;
    step();

    q.delete();
    for (int i = 0; i < NN; i++) q.push_back(8'(i));
    session(q, 0);
    chk("b2b_single_run", rises, 1);

    pulse_start();
    w_data = 8'hA5;
    w_valid = 1;
    chk("gap_ready", w_ready, 1);
    step();
    w_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("gap_en", load_en, en_e[k-1]);
      if (en_e[k-1]) chk("gap_nibble", load_nibble, nb_e[k-1]);
      if (k == 4) begin
        w_data = 8'h3C;
        w_valid = 1;
      end
      if (k == 5) w_valid = 0;
    end
    pulse_start();
    chk("start_busy_ignored", neuron_idx, 2);
    abort = 1;
    step();
    abort = 0;
    chk("abort_lo_done", done, 1);
    step();
    chk("abort_lo_idx", neuron_idx, 2);
    chk("abort_lo_done_clear", done, 0);

    pulse_start();
    w_data = 8'hF0;
    w_valid = 1;
    step();
    w_data = 8'h77;
    step();
    w_valid = 0;
    chk("abort_hi_low", load_nibble, 0);
    abort = 1;
    step();
    abort = 0;
    chk("abort_hi_en", load_en, 1);
    chk("abort_hi_high", load_nibble, 4'hF);
    chk("abort_hi_done", done, 1);
    step();
    chk("abort_after_en", load_en, 0);
    chk("abort_after_idx", neuron_idx, 1);
    chk("abort_after_busy", busy, 0);
`ifdef WSTREAM_CHECKSUM_EN
    chk("abort_checksum", checksum, 8'hF0);
`endif
    pulse_start();
    obs.delete();
    repeat (4) step();
    chk("abort_flushed", obs.size(), 0);
    abort = 1;
    step();
    abort = 0;
    step();

    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    chk("abort_beats_start", busy, 0);

    pulse_start();
    w_data = 8'h5A;
    w_valid = 1;
    step();
    w_valid = 0;
    step();
    chk("pre_reset_en", load_en, 1);
    reset = 1;
    #1;
    chk("async_rst_en", load_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", w_ready, 0);
    step();
    reset = 0;
    step();
    pulse_start();
    obs.delete();
    repeat (4) step();
    chk("rst_flushed", obs.size(), 0);
    chk("rst_restart_busy", busy, 1);
    abort = 1;
    step();
    abort = 0;
    step();

    q.delete();
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    session(q, 0);
    chk("fifo_full_seen", saw_full, 1);

    for (int s = 0; s < 3; s++) begin
      q.delete();
      for (int i = 0; i < NN + int'($urandom_range(2, 0)); i++) q.push_back(8'($urandom));
      session(q, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
